// File: rtl/tmu_pkg.sv
// Shared constants and sizing helpers for the texture fetch scheduler.
// Quad packing puts slot {11,10,01,00} of TMU0 in the LSBs.
package tmu_pkg;

    localparam int QUAD        = 4;
    localparam int PIXEL_WIDTH = 32;

    function automatic int pixel_w(input int sub_w);
        return QUAD * sub_w;
    endfunction

    function automatic int quad_w(input int w);
        return QUAD * w;
    endfunction

    function automatic int quad_lsb(input int tmu, input int w);
        return tmu * QUAD * w;
    endfunction

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/tmu_sync_fifo.sv
// First-word-fall-through synchronous FIFO (DEPTH a power of two).
// Ports: push_i/pop_i/data_i in; empty_o/full_o/head_o out.
// A push while full is taken only when a pop happens in the same cycle.
module tmu_sync_fifo
    import tmu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             empty_o,
    output logic             full_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int AW = ptr_w(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign head_o  = mem_q[rd_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) wr_d = wr_q + 1'b1;
        if (do_pop)  rd_d = rd_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/tmu_fetch_scheduler.sv
// Texel-quad fetch scheduler for NUM_TMU units over variable-latency memory.
// Accepts fragments (s_frag_*), issues one quad request per enabled TMU
// (tex_req_*), joins in-order responses (tex_resp_*) with buffered side data
// and emits them in order (m_frag_*). err_unexpected_resp is sticky.
// Macro TMU_FETCH_PERF_COUNTERS_EN adds perf_frag_cnt / perf_stall_cnt.
module tmu_fetch_scheduler
    import tmu_pkg::*;
#(
    parameter int NUM_TMU         = 2,
    parameter int SUB_PIXEL_WIDTH = PIXEL_WIDTH / QUAD,
    parameter int ADDR_WIDTH      = 17,
    parameter int SIDE_WIDTH      = 64,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic                  aclk,
    input  logic                  resetn,
    input  logic [NUM_TMU-1:0]    conf_tmu_enable,
    input  logic                  s_frag_valid,
    output logic                  s_frag_ready,
    input  logic [NUM_TMU*quad_w(ADDR_WIDTH)-1:0] s_frag_addr,
    input  logic [SIDE_WIDTH-1:0] s_frag_side,
    output logic [NUM_TMU-1:0]    tex_req_valid,
    input  logic [NUM_TMU-1:0]    tex_req_ready,
    output logic [NUM_TMU*quad_w(ADDR_WIDTH)-1:0] tex_req_addr,
    input  logic [NUM_TMU-1:0]    tex_resp_valid,
    input  logic [NUM_TMU*quad_w(pixel_w(SUB_PIXEL_WIDTH))-1:0] tex_resp_data,
    output logic                  m_frag_valid,
    input  logic                  m_frag_ready,
    output logic [NUM_TMU*quad_w(pixel_w(SUB_PIXEL_WIDTH))-1:0] m_frag_texels,
    output logic [SIDE_WIDTH-1:0] m_frag_side,
`ifdef TMU_FETCH_PERF_COUNTERS_EN
    output logic [31:0]           perf_frag_cnt,
    output logic [31:0]           perf_stall_cnt,
`endif
    output logic                  err_unexpected_resp
);

    localparam int PW = pixel_w(SUB_PIXEL_WIDTH);
    localparam int AQ = quad_w(ADDR_WIDTH);
    localparam int TQ = quad_w(PW);
    localparam int CW = ptr_w(FIFO_DEPTH) + 1;
    localparam int EW = NUM_TMU + SIDE_WIDTH;

    logic [NUM_TMU-1:0]    pend_q, pend_d;
    logic [NUM_TMU*AQ-1:0] addr_q;
    logic [CW-1:0]         outst_q, outst_d;
    logic                  err_q, err_d;
    logic [NUM_TMU-1:0]    req_hs, resp_pop, resp_empty, bad_resp;
    logic [NUM_TMU-1:0]    head_mask;
    logic [EW-1:0]         side_head;
    logic                  side_empty, side_full;
    logic                  at_cap, accept, out_hs;

    assign req_hs       = pend_q & tex_req_ready;
    assign at_cap       = (outst_q == CW'(FIFO_DEPTH)) || side_full;
    assign head_mask    = side_head[SIDE_WIDTH +: NUM_TMU];
    assign m_frag_valid = !side_empty && ((head_mask & resp_empty) == '0);
    assign out_hs       = m_frag_valid && m_frag_ready;
    assign resp_pop     = out_hs ? head_mask : '0;

    // A channel issuing this cycle frees its slot, so fragments
    // can be accepted back to back.
    assign s_frag_ready = resetn
                       && ((pend_q & ~tex_req_ready) == '0)
                       && (!at_cap || out_hs);
    assign accept       = s_frag_valid && s_frag_ready;

    assign tex_req_valid       = pend_q;
    assign tex_req_addr        = addr_q;
    assign m_frag_side         = side_head[SIDE_WIDTH-1:0];
    assign err_unexpected_resp = err_q;

    tmu_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_side_fifo (
        .clk_i   (aclk),
        .rst_ni  (resetn),
        .push_i  (accept),
        .pop_i   (out_hs),
        .data_i  ({conf_tmu_enable, s_frag_side}),
        .empty_o (side_empty),
        .full_o  (side_full),
        .head_o  (side_head)
    );

    for (genvar i = 0; i < NUM_TMU; i++) begin : g_tmu
        logic [CW-1:0] cnt_q, cnt_d;
        logic [TQ-1:0] head;
        logic          full, take, push;

        assign bad_resp[i] = tex_resp_valid[i] && (cnt_q == '0);
        assign take        = tex_resp_valid[i] && !bad_resp[i];
        assign push        = take && (!full || resp_pop[i]);

        always_comb begin
            cnt_d = cnt_q;
            case ({req_hs[i], take})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end

        always_ff @(posedge aclk or negedge resetn) begin
            if (!resetn) cnt_q <= '0;
            else         cnt_q <= cnt_d;
        end

        tmu_sync_fifo #(
            .WIDTH (TQ),
            .DEPTH (FIFO_DEPTH)
        ) u_resp_fifo (
            .clk_i   (aclk),
            .rst_ni  (resetn),
            .push_i  (push),
            .pop_i   (resp_pop[i]),
            .data_i  (tex_resp_data[quad_lsb(i, PW) +: TQ]),
            .empty_o (resp_empty[i]),
            .full_o  (full),
            .head_o  (head)
        );

        assign m_frag_texels[quad_lsb(i, PW) +: TQ] = head_mask[i] ? head : '0;
    end

    always_comb begin
        pend_d = pend_q & ~tex_req_ready;
        if (accept) pend_d = conf_tmu_enable;
        outst_d = outst_q;
        case ({accept, out_hs})
            2'b10:   outst_d = outst_q + 1'b1;
            2'b01:   outst_d = outst_q - 1'b1;
            default: outst_d = outst_q;
        endcase
        err_d = err_q | (|bad_resp);
    end

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            pend_q  <= '0;
            addr_q  <= '0;
            outst_q <= '0;
            err_q   <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            outst_q <= outst_d;
            err_q   <= err_d;
            if (accept) addr_q <= s_frag_addr;
        end
    end

`ifdef TMU_FETCH_PERF_COUNTERS_EN
    logic [31:0] frag_cnt_q, stall_cnt_q;

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            frag_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            frag_cnt_q  <= frag_cnt_q + 32'(out_hs);
            stall_cnt_q <= stall_cnt_q + 32'(!side_empty && !m_frag_valid);
        end
    end

    assign perf_frag_cnt  = frag_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule
